dmem_arbiter: RTL and testbench

//  Shares the single DataMemory instance between two requesters:
//   - port C: the CPU load/store path.
//   - port L: the program/data loader and debug port.

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one DataMemory between the CPU port (C) and the loader/debug port (L).
// One transaction at a time via IDLE/ACCESS/RESP; round-robin on ties; combinational stall to C.
//   Ports: CLK, resetl (async, active-low); c_* CPU port; l_* loader port; mem_* memory side.
module dmem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic              c_err,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic              l_err,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic SEL_C = 1'b0;
  localparam logic SEL_L = 1'b1;

  state_t            r_state;
  state_t            w_next;
  logic              r_sel;
  logic              r_last;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_l_rdata;

  logic              w_grant;
  logic              w_gsel;
  logic              w_misal;
  logic              w_resp;

  assign w_misal = |r_addr[2:0];

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_gsel    = SEL_C;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (c_req | l_req) begin
          w_grant = 1'b1;
          // tie goes to whoever was not served last
          if (c_req & l_req) w_gsel = ~r_last;
          else               w_gsel = l_req;
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_read  = ~r_we & ~w_misal;
        mem_write =  r_we & ~w_misal;
        w_next    = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state   <= S_IDLE;
      r_sel     <= SEL_C;
      r_last    <= SEL_L;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_c_rdata <= '0;
      r_l_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_sel   <= w_gsel;
        r_last  <= w_gsel;
        r_we    <= w_gsel ? l_we    : c_we;
        r_addr  <= w_gsel ? l_addr  : c_addr;
        r_wdata <= w_gsel ? l_wdata : c_wdata;
      end
      if (r_state == S_ACCESS) begin
        r_err <= w_misal;
        if (~r_we & ~w_misal) begin
          if (r_sel) r_l_rdata <= mem_rdata;
          else       r_c_rdata <= mem_rdata;
        end
      end
    end
  end

  assign w_resp    = (r_state == S_RESP);
  assign c_ack     = w_resp & ~r_sel;
  assign l_ack     = w_resp &  r_sel;
  assign c_err     = c_ack & r_err;
  assign l_err     = l_ack & r_err;
  assign c_stall   = c_req & ~c_ack;
  assign c_rdata   = r_c_rdata;
  assign l_rdata   = r_l_rdata;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small behavioural memory.
// Checks are immediate assertions; one summary line at the end.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        c_req, c_we, l_req, l_we;
  logic [63:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_ack, c_err, c_stall, l_ack, l_err;
  logic [63:0] c_rdata, l_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [63:0] tmem [0:15];

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .CLK(CLK), .resetl(resetl),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata), .c_stall(c_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_err(l_err), .l_rdata(l_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = tmem[mem_addr[6:3]];

  always @(posedge CLK)
    if (mem_write) tmem[mem_addr[6:3]] <= mem_wdata;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tmem[i] = {8{8'(i)}};
    resetl = 1'b0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    #3;
    chk1 ("rst_c_ack", c_ack, 1'b0);
    chk1 ("rst_l_ack", l_ack, 1'b0);
    chk1 ("rst_mem_wr", mem_write, 1'b0);
    chk1 ("rst_mem_rd", mem_read, 1'b0);
    chk64("rst_mem_addr", mem_addr, 64'h0);
    chk64("rst_c_rdata", c_rdata, 64'h0);
    chk64("rst_l_rdata", l_rdata, 64'h0);

    // 1: store 0xDEAD to 0x28, then load it back
    #9 resetl = 1'b1;
    c_req = 1; c_we = 1; c_addr = 64'h28; c_wdata = 64'hDEAD;
    #1;
    chk1("t1_stall_idle", c_stall, 1'b1);
    tick;
    chk1 ("t1_mem_write", mem_write, 1'b1);
    chk1 ("t1_mem_read", mem_read, 1'b0);
    chk64("t1_mem_addr", mem_addr, 64'h28);
    chk64("t1_mem_wdata", mem_wdata, 64'hDEAD);
    chk1 ("t1_no_ack_early", c_ack, 1'b0);
    tick;
    chk1("t1_c_ack", c_ack, 1'b1);
    chk1("t1_c_err", c_err, 1'b0);
    chk1("t1_stall_ack", c_stall, 1'b0);
    chk1("t1_wr_resp", mem_write, 1'b0);
    c_we = 0;
    tick;
    chk1("t1_idle_ack", c_ack, 1'b0);
    tick;
    chk1 ("t1_ld_read", mem_read, 1'b1);
    chk64("t1_ld_addr", mem_addr, 64'h28);
    tick;
    chk1 ("t1_ld_ack", c_ack, 1'b1);
    chk64("t1_ld_data", c_rdata, 64'hDEAD);
    c_req = 0;
    tick;
    chk64("t1_rdata_held", c_rdata, 64'hDEAD);

    // 2: both requesting from reset alternate C, L, C, L
    resetl = 1'b0;
    c_req = 1; c_we = 0; c_addr = 64'h28;
    l_req = 1; l_we = 0; l_addr = 64'h30;
    #2 resetl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk1("t2_access_rd", mem_read, 1'b1);
      chk1("t2_access_stall", c_stall, 1'b1);
      tick;
      chk1("t2_c_ack", c_ack, (i % 2) == 0);
      chk1("t2_l_ack", l_ack, (i % 2) == 1);
      chk1("t2_stall", c_stall, (i % 2) == 1);
      if (i == 1) chk64("t2_l_rdata", l_rdata, 64'h0606060606060606);
      tick;
      chk1("t2_idle_c_ack", c_ack, 1'b0);
      chk1("t2_idle_l_ack", l_ack, 1'b0);
    end

    // 3: misaligned loader write errors without touching memory
    c_req = 0;
    l_req = 1; l_we = 1; l_addr = 64'h13; l_wdata = 64'h1234;
    tick;
    chk1("t3_no_wr", mem_write, 1'b0);
    chk1("t3_no_rd", mem_read, 1'b0);
    tick;
    chk1 ("t3_l_ack", l_ack, 1'b1);
    chk1 ("t3_l_err", l_err, 1'b1);
    chk1 ("t3_c_ack", c_ack, 1'b0);
    chk1 ("t3_resp_wr", mem_write, 1'b0);
    chk64("t3_l_rdata", l_rdata, 64'h0606060606060606);
    l_req = 0;
    tick;
    chk1("t3_err_gone", l_err, 1'b0);

    // 4: reset during a store's ACCESS cycle
    c_req = 1; c_we = 1; c_addr = 64'h40; c_wdata = 64'hBEEF;
    tick;
    chk1("t4_wr_on", mem_write, 1'b1);
    #2 resetl = 1'b0;
    #1;
    chk1("t4_wr_async_off", mem_write, 1'b0);
    c_we = 0; c_addr = 64'h28;
    l_req = 1; l_we = 0; l_addr = 64'h30;
    tick;
    chk1 ("t4_no_c_ack", c_ack, 1'b0);
    chk1 ("t4_no_l_ack", l_ack, 1'b0);
    chk64("t4_mem_kept", tmem[8], 64'h0808080808080808);
    #3 resetl = 1'b1;
    tick;
    chk1 ("t4_c_first_rd", mem_read, 1'b1);
    chk64("t4_c_first_addr", mem_addr, 64'h28);
    tick;
    chk1 ("t4_c_ack", c_ack, 1'b1);
    chk1 ("t4_l_wait", l_ack, 1'b0);
    chk64("t4_c_rdata", c_rdata, 64'hDEAD);
    c_req = 0; l_req = 0;
    tick;

    // 5: L pulsed alone, C arrives during L's RESP
    l_req = 1; l_we = 0; l_addr = 64'h30;
    tick;
    l_req = 0;
    chk64("t5_l_addr", mem_addr, 64'h30);
    tick;
    chk1 ("t5_l_ack", l_ack, 1'b1);
    chk64("t5_l_rdata", l_rdata, 64'h0606060606060606);
    c_req = 1; c_we = 0; c_addr = 64'h18;
    tick;
    chk1("t5_idle_stall", c_stall, 1'b1);
    chk1("t5_idle_c_ack", c_ack, 1'b0);
    tick;
    chk1 ("t5_c_rd", mem_read, 1'b1);
    chk64("t5_c_addr", mem_addr, 64'h18);
    tick;
    chk1 ("t5_c_ack", c_ack, 1'b1);
    chk64("t5_c_rdata", c_rdata, 64'h0303030303030303);
    c_req = 0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
